key_event_decoder: RTL and testbench

- Consumer end of the key debouncer: takes the debounced key level and classifies each press as short, long or double-click.
- Emits single-cycle event pulses for the application logic: menu, mode switch, LED and buzzer control.
- Sits directly after the debouncer, in the same clk domain.

---
 rtl/key_pkg.sv | 34 +++
 rtl/key_edge_detect.sv | 42 ++++
 rtl/key_event_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_key_event_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------------------------
// key_pkg
//   Shared types and default timing for the key event decoder and its input stage.
//   - key_state_t : classifier state encoding.
//   - *_CNT_DEF   : default timing constants, in clk cycles at 100 MHz.
//   - max3        : helper used to size the shared interval counter.
// ---------------------------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } key_state_t;

    // 1 s long-press threshold
    localparam int unsigned LONG_CNT_DEF   = 100_000_000;
    // 300 ms double-click window
    localparam int unsigned DCLICK_CNT_DEF = 30_000_000;
    // 200 ms auto-repeat period
    localparam int unsigned REPEAT_CNT_DEF = 20_000_000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// ---------------------------------------------------------------------------------------------
// key_edge_detect
//   Polarity fix and edge extraction for a debounced key level already in the clk domain.
//   Ports:
//     clk          in   system clock
//     rst          in   synchronous reset, active-high
//     kin          in   debounced key level
//     pressed      out  combinational "key pressed" after polarity fix
//     pressed_q    out  pressed, registered; resets to 1
//     press_edge   out  pressed & ~pressed_q
//     release_edge out  ~pressed & pressed_q
//   pressed_q resets to "pressed" so a key held through reset produces no press edge until it
//   has been released and pressed again.
// ---------------------------------------------------------------------------------------------
module key_edge_detect
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic kin,
    output logic pressed,
    output logic pressed_q,
    output logic press_edge,
    output logic release_edge
);

    assign pressed = kin ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            pressed_q <= 1'b1;
        end else begin
            pressed_q <= pressed;
        end
    end

    assign press_edge   = pressed & ~pressed_q;
    assign release_edge = ~pressed & pressed_q;

endmodule

// File: rtl/key_event_decoder.sv
// ---------------------------------------------------------------------------------------------
// key_event_decoder
//   Classifies each press of a debounced key as a short click, long press or double-click and
//   emits single-cycle event pulses.
//   Parameters:
//     LONG_CNT   cycles a press must be held to count as long
//     DCLICK_CNT window after a short release in which a second press makes a double-click
//     REPEAT_CNT auto-repeat period while held after a long press (KEY_REPEAT_EN only)
//     ACTIVE_LOW 1: kin low means pressed; 0: kin high means pressed
//   Ports:
//     clk          in   system clock
//     rst          in   synchronous reset, active-high
//     kin          in   debounced key level
//     short_pulse  out  one-cycle pulse for a single short click
//     long_pulse   out  one-cycle pulse when the long threshold is reached while held
//     double_pulse out  one-cycle pulse on release of the second click
//     held         out  registered "key currently pressed" level
//     repeat_pulse out  one-cycle auto-repeat pulse; constant 0 unless KEY_REPEAT_EN
//   Build option:
//     KEY_REPEAT_EN  when defined, LONG counts and fires repeat_pulse every REPEAT_CNT cycles.
//   Timing: the FSM decides on the edge that first samples the deciding kin level; the decision
//   is then carried through one output register, so every pulse (and held) appears one edge
//   later. Reset clears both stages, so a pending pulse is dropped.
// ---------------------------------------------------------------------------------------------
module key_event_decoder
    import key_pkg::*;
#(
    parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
    parameter int unsigned DCLICK_CNT = DCLICK_CNT_DEF,
    parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic kin,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic held,
    output logic repeat_pulse
);

    localparam int unsigned CNT_W = $clog2(max3(LONG_CNT, DCLICK_CNT, REPEAT_CNT) + 1);

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_TERM = CNT_W'(DCLICK_CNT - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CNT - 1);
`endif

    logic pressed;
    logic pressed_q;
    logic press_edge;
    logic release_edge;

    key_edge_detect #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_edge (
        .clk          (clk),
        .rst          (rst),
        .kin          (kin),
        .pressed      (pressed),
        .pressed_q    (pressed_q),
        .press_edge   (press_edge),
        .release_edge (release_edge)
    );

    key_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;

    // FSM decision flags, one cycle ahead of the output pulses
    logic evt_short_q;
    logic evt_long_q;
    logic evt_double_q;
`ifdef KEY_REPEAT_EN
    logic evt_repeat_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            evt_short_q  <= 1'b0;
            evt_long_q   <= 1'b0;
            evt_double_q <= 1'b0;
`ifdef KEY_REPEAT_EN
            evt_repeat_q <= 1'b0;
`endif
        end else begin
            evt_short_q  <= 1'b0;
            evt_long_q   <= 1'b0;
            evt_double_q <= 1'b0;
`ifdef KEY_REPEAT_EN
            evt_repeat_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (press_edge) begin
                        state_q <= PRESS1;
                    end
                end

                // Terminal count wins over a simultaneous release: that press counts as long.
                PRESS1: begin
                    if (cnt_q == LONG_TERM) begin
                        evt_long_q <= 1'b1;
                        state_q    <= LONG;
                        cnt_q      <= '0;
                    end else if (release_edge) begin
                        state_q <= WAIT2;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // A press on the terminal cycle still counts as the second click.
                WAIT2: begin
                    if (press_edge) begin
                        state_q <= PRESS2;
                        cnt_q   <= '0;
                    end else if (cnt_q == DCLICK_TERM) begin
                        evt_short_q <= 1'b1;
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // Holding the second click long discards the first click entirely.
                PRESS2: begin
                    if (cnt_q == LONG_TERM) begin
                        evt_long_q <= 1'b1;
                        state_q    <= LONG;
                        cnt_q      <= '0;
                    end else if (release_edge) begin
                        evt_double_q <= 1'b1;
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // Exit on the level, not the edge: a release on the terminal cycle of PRESS1/2
                // has already been consumed and must still bring us back to IDLE.
                LONG: begin
                    if (!pressed) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
`ifdef KEY_REPEAT_EN
                    end else if (cnt_q == REPEAT_TERM) begin
                        evt_repeat_q <= 1'b1;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`else
                    end else begin
                        cnt_q <= '0;
                    end
`endif
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;
            held         <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_pulse <= 1'b0;
`endif
        end else begin
            short_pulse  <= evt_short_q;
            long_pulse   <= evt_long_q;
            double_pulse <= evt_double_q;
            held         <= pressed_q;
`ifdef KEY_REPEAT_EN
            repeat_pulse <= evt_repeat_q;
`endif
        end
    end

`ifndef KEY_REPEAT_EN
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// ---------------------------------------------------------------------------------------------
// tb_key_event_decoder
//   Scoreboard bench. Each phase is a reset followed by a list of key levels (1 = pressed).
//   Before a phase is driven, a reference model splits the levels into press intervals,
//   classifies them by duration and gap, and queues the expected pulses with their edge number.
//   A negedge monitor pops and compares whenever the DUT shows a pulse, and checks held.
// ---------------------------------------------------------------------------------------------
module tb_key_event_decoder;

    localparam int  LONG_CNT   = 20;
    localparam int  DCLICK_CNT = 8;
    localparam int  REPEAT_CNT = 5;
    localparam bit  ACTIVE_LOW = 1'b1;
    localparam int  MAXE       = 20000;

    localparam int  K_SHORT  = 0;
    localparam int  K_LONG   = 1;
    localparam int  K_DOUBLE = 2;
    localparam int  K_REPEAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kin = 1'b1;
    logic short_pulse;
    logic long_pulse;
    logic double_pulse;
    logic held;
    logic repeat_pulse;

    always #5 clk = ~clk;

    key_event_decoder #(
        .LONG_CNT   (LONG_CNT),
        .DCLICK_CNT (DCLICK_CNT),
        .REPEAT_CNT (REPEAT_CNT),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .kin          (kin),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .double_pulse (double_pulse),
        .held         (held),
        .repeat_pulse (repeat_pulse)
    );

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    ev_t exp_q[$];
    int  n_pass   = 0;
    int  n_checks = 0;
    int  edge_n   = 0;
    bit  mon_en   = 1'b0;
    bit  exp_held   [MAXE];
    bit  held_known [MAXE];
    bit  lv[$];
    int  np;
    int  act_kind;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, req);
    endtask

    task automatic add(input bit l, input int n);
        repeat (n) lv.push_back(l);
    endtask

    // Level index idx is sampled on edge s0+idx; a decision there shows on the next edge.
    task automatic emit(input int s0, input int idx, input int len, input int kind);
        ev_t ev;
        if (idx + 1 <= len - 1) begin
            ev.cyc  = s0 + idx + 1;
            ev.kind = kind;
            exp_q.push_back(ev);
        end
    endtask

    task automatic add_long(input int s0, input int s, input int r, input int len);
        emit(s0, s + LONG_CNT, len, K_LONG);
`ifdef KEY_REPEAT_EN
        for (int e = s + LONG_CNT + REPEAT_CNT; e < r && e < len; e += REPEAT_CNT)
            emit(s0, e, len, K_REPEAT);
`endif
    endtask

    task automatic drive(input bit r, input bit p);
        rst = r;
        kin = p ^ ACTIVE_LOW;
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic run_phase(input int nr, input string tag);
        int base, len, s0, open, k;
        bit prev;
        int st[$];
        int rl[$];
        base = edge_n;
        len  = lv.size();
        s0   = base + nr + 1;
        for (int e = 1; e <= nr; e++) begin
            exp_held[base + e]   = 1'b0;
            held_known[base + e] = 1'b1;
        end
        // held shows the previously sampled level; reset leaves it looking pressed.
        for (int i = 0; i < len; i++) begin
            exp_held[s0 + i]   = (i == 0) ? 1'b1 : lv[i - 1];
            held_known[s0 + i] = 1'b1;
        end
        // Press intervals; a release of a key held through reset has no start and is ignored.
        prev = 1'b1;
        open = -1;
        for (int i = 0; i < len; i++) begin
            if (lv[i] && !prev) open = i;
            if (!lv[i] && prev && open >= 0) begin
                st.push_back(open);
                rl.push_back(i);
                open = -1;
            end
            prev = lv[i];
        end
        if (open >= 0) begin
            st.push_back(open);
            rl.push_back(len + 1000);
        end
        k = 0;
        while (k < st.size()) begin
            if (rl[k] - st[k] >= LONG_CNT) begin
                add_long(s0, st[k], rl[k], len);
                k++;
            end else if (k + 1 < st.size() && st[k + 1] - rl[k] <= DCLICK_CNT) begin
                if (rl[k + 1] - st[k + 1] >= LONG_CNT) add_long(s0, st[k + 1], rl[k + 1], len);
                else emit(s0, rl[k + 1], len, K_DOUBLE);
                k += 2;
            end else begin
                emit(s0, rl[k] + DCLICK_CNT, len, K_SHORT);
                k++;
            end
        end
        for (int i = 0; i < nr; i++) drive(1'b1, (len > 0) ? lv[0] : 1'b0);
        for (int i = 0; i < len; i++) drive(1'b0, lv[i]);
        @(negedge clk);
        #1;
        check({"drained_", tag}, exp_q.size(), 0);
        exp_q.delete();
        lv.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            np = int'(short_pulse) + int'(long_pulse) + int'(double_pulse) + int'(repeat_pulse);
            act_kind = repeat_pulse ? K_REPEAT : double_pulse ? K_DOUBLE :
                       long_pulse ? K_LONG : short_pulse ? K_SHORT : -1;
            if (np > 1) check("one_pulse_per_cycle", np, 1);
            while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
                check("pulse_missing", -1, exp_q[0].kind);
                void'(exp_q.pop_front());
            end
            if (np > 0) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
                    check("pulse_kind", act_kind, exp_q[0].kind);
                    void'(exp_q.pop_front());
                end else begin
                    check("pulse_unexpected", act_kind, -1);
                end
            end
            if (edge_n < MAXE && held_known[edge_n])
                check("held", int'(held), int'(exp_held[edge_n]));
        end
    end

    initial begin
        int dur, gap;
        mon_en = 1'b1;

        add(0, 3); add(1, 5); add(0, 20);
        run_phase(3, "short_click");

        add(0, 3); add(1, 4); add(0, 3); add(1, 4); add(0, 20);
        run_phase(2, "double_click");

        add(0, 3); add(1, 40); add(0, 30);
        run_phase(2, "long_press");

        add(1, 10); add(0, 5); add(1, 5); add(0, 20);
        run_phase(3, "held_through_reset");

        // release exactly on the long terminal cycle, then one cycle short of it
        add(0, 3); add(1, 20); add(0, 10); add(1, 19); add(0, 20);
        run_phase(2, "long_terminal");

        // second press on the last window cycle, then one cycle past it
        add(0, 3); add(1, 3); add(0, 8); add(1, 3); add(0, 12);
        add(1, 3); add(0, 9); add(1, 3); add(0, 20);
        run_phase(2, "dclick_terminal");

        add(0, 3); add(1, 4); add(0, 3); add(1, 30); add(0, 20);
        run_phase(2, "press2_long");

        add(0, 3); add(1, 5); add(0, 3);
        run_phase(2, "reset_mid_wait2");

        add(0, 3); add(1, 5); add(0, 20);
        run_phase(2, "after_reset");

        for (int p = 0; p < 6; p++) begin
            add(0, 3);
            for (int n = 0; n < 10; n++) begin
                case ($urandom_range(0, 3))
                    0:       dur = int'($urandom_range(1, 6));
                    1:       dur = int'($urandom_range(17, 21));
                    2:       dur = int'($urandom_range(22, 30));
                    default: dur = int'($urandom_range(2, 10));
                endcase
                gap = int'($urandom_range(2, 12));
                add(1, dur);
                add(0, gap);
            end
            add(0, 30);
            run_phase(2, "random");
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
